// File: rtl/nand_cal_pkg.sv
// Shared definitions for NAND PHY read-strobe / data delay calibration.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package nand_cal_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TAP_RST,
    ST_SETTLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL,
    ST_STEP,
    ST_CTR_RST,
    ST_CTR_INC,
    ST_CTR_SETTLE,
    ST_DONE,
    ST_ERR
  } cal_state_e;

  // Centre of a window, rounding towards the window start for even lengths.
  // Done one bit wider than a tap so start + half can never wrap.
  function automatic logic [TAP_W:0] centre_tap(input logic [TAP_W-1:0] start,
                                                input logic [TAP_W:0]   len);
    logic [TAP_W:0] half;
    half = (len - (TAP_W+1)'(1)) >> 1;
    return {1'b0, start} + half;
  endfunction

endpackage

// File: rtl/nand_dqs_win_track.sv
// Tracks the current passing run and the longest run seen over a tap sweep.
// Latency: best_* reflect a sample one cycle after smp_vld_i.
// Backpressure: none; one sample accepted per cycle.
module nand_dqs_win_track
  import nand_cal_pkg::*;
#(
  parameter int TW = TAP_W
) (
  input  logic          clk0,
  input  logic          rst0_n,
  input  logic          clr_i,
  input  logic          smp_vld_i,
  input  logic          pass_i,
  input  logic [TW-1:0] tap_i,
  input  logic          last_i,
  output logic [TW-1:0] best_start_o,
  output logic [TW:0]   best_len_o
);

  logic          run_open_q;
  logic [TW-1:0] run_start_q;
  logic [TW:0]   run_len_q;
  logic [TW-1:0] best_start_q;
  logic [TW:0]   best_len_q;

  // Extend or close the open run on each sample; a run only displaces the best on strictly greater length.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (clr_i) begin
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (smp_vld_i) begin
      if (pass_i) begin
        if (last_i) begin
          // Run touching the final tap is closed here so it still competes.
          if ((run_len_q + (TW+1)'(1)) > best_len_q) begin
            best_start_q <= run_open_q ? run_start_q : tap_i;
            best_len_q   <= run_len_q + (TW+1)'(1);
          end
          run_open_q <= 1'b0;
          run_len_q  <= '0;
        end else begin
          run_open_q  <= 1'b1;
          run_start_q <= run_open_q ? run_start_q : tap_i;
          run_len_q   <= run_len_q + (TW+1)'(1);
        end
      end else begin
        if (run_open_q && (run_len_q > best_len_q)) begin
          best_start_q <= run_start_q;
          best_len_q   <= run_len_q;
        end
        run_open_q <= 1'b0;
        run_len_q  <= '0;
      end
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/nand_dqs_cal_ctrl.sv
// Read-DQS IDELAY calibration: sweep all taps, find the longest passing window, park at its centre.
// Latency: ~NUM_TAPS*(SETTLE_CYCLES+read latency+3) cycles per calibration run.
// Backpressure: rd_req is held until rd_ack; a read not completed within TIMEOUT_CYCLES aborts to error.
module nand_dqs_cal_ctrl #(
  parameter int TAP_W          = 5,
  parameter int NUM_TAPS       = 32,
  parameter int SETTLE_CYCLES  = 8,
  parameter int MIN_WINDOW     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk0,
  input  logic             rst0_n,
  input  logic             cal_start,
  output logic             rd_req,
  input  logic             rd_ack,
  input  logic             rd_done,
  input  logic             rd_pass,
  output logic             dlyrst_dqs,
  output logic             dlyce_dqs,
  output logic             dlyinc_dqs,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_err,
  output logic [TAP_W-1:0] cur_tap,
  output logic [TAP_W-1:0] win_start,
  output logic [TAP_W:0]   win_len
);
  import nand_cal_pkg::*;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  cal_state_e       state_q;
  logic [TAP_W-1:0] cur_tap_q;
  logic [TAP_W:0]   centre_q;
  logic [SET_W-1:0] settle_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ctr_ph_q;
  logic             pass_q;
  logic             rd_req_q;
  logic             dlyrst_q;
  logic             dlyce_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic start_ok;
  logic last_tap;
  logic settle_end;
  logic tmo_hit;

  assign start_ok   = cal_start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign last_tap   = (cur_tap_q == TAP_W'(NUM_TAPS - 1));
  assign settle_end = (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign tmo_hit    = (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));

  nand_dqs_win_track #(
    .TW (TAP_W)
  ) u_win_track (
    .clk0         (clk0),
    .rst0_n       (rst0_n),
    .clr_i        (start_ok),
    .smp_vld_i    (state_q == ST_EVAL),
    .pass_i       (pass_q),
    .tap_i        (cur_tap_q),
    .last_i       (last_tap),
    .best_start_o (win_start),
    .best_len_o   (win_len)
  );

  // Calibration sequencer; tap-control pulses default low every cycle so each one lasts a single cycle.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q   <= ST_IDLE;
      cur_tap_q <= '0;
      centre_q  <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      ctr_ph_q  <= 1'b0;
      pass_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      dlyrst_q  <= 1'b0;
      dlyce_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dlyrst_q <= 1'b0;
      dlyce_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (cal_start) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            cur_tap_q <= '0;
            centre_q  <= '0;
            dlyrst_q  <= 1'b1;
            state_q   <= ST_TAP_RST;
          end
        end
        ST_TAP_RST: begin
          settle_q <= '0;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_end) begin
            tmo_q    <= '0;
            rd_req_q <= 1'b1;
            state_q  <= ST_REQ;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            rd_req_q <= 1'b0;
            tmo_q    <= tmo_q + TMO_W'(1);
            state_q  <= ST_WAIT;
          end else if (tmo_hit) begin
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= ST_ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_WAIT: begin
          if (rd_done) begin
            pass_q  <= rd_pass;
            state_q <= ST_EVAL;
          end else if (tmo_hit) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_EVAL: begin
          // The last tap is never stepped past, so the IDELAY cannot wrap.
          if (last_tap) begin
            ctr_ph_q <= 1'b0;
            state_q  <= ST_CTR_RST;
          end else begin
            dlyce_q <= 1'b1;
            state_q <= ST_STEP;
          end
        end
        ST_STEP: begin
          cur_tap_q <= cur_tap_q + TAP_W'(1);
          settle_q  <= '0;
          state_q   <= ST_SETTLE;
        end
        ST_CTR_RST: begin
          // First cycle judges the now-final window; the tap reset pulse only follows if it is usable.
          if (!ctr_ph_q) begin
            if (win_len < (TAP_W+1)'(MIN_WINDOW)) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end else begin
              centre_q  <= centre_tap(win_start, win_len);
              cur_tap_q <= '0;
              dlyrst_q  <= 1'b1;
              ctr_ph_q  <= 1'b1;
            end
          end else begin
            settle_q <= '0;
            if (centre_q == '0) begin
              state_q <= ST_CTR_SETTLE;
            end else begin
              dlyce_q <= 1'b1;
              state_q <= ST_CTR_INC;
            end
          end
        end
        ST_CTR_INC: begin
          cur_tap_q <= cur_tap_q + TAP_W'(1);
          if (({1'b0, cur_tap_q} + (TAP_W+1)'(1)) == centre_q) begin
            settle_q <= '0;
            state_q  <= ST_CTR_SETTLE;
          end else begin
            dlyce_q <= 1'b1;
          end
        end
        ST_CTR_SETTLE: begin
          if (settle_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_req     = rd_req_q;
  assign dlyrst_dqs = dlyrst_q;
  assign dlyce_dqs  = dlyce_q;
  assign dlyinc_dqs = 1'b1;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_err    = err_q;
  assign cur_tap    = cur_tap_q;

endmodule

// File: tb/tb_nand_dqs_cal_ctrl.sv
// Directed bench for nand_dqs_cal_ctrl with a read-path responder and an IDELAY tap model.
// Latency: n/a.
// Backpressure: responder acks every rd_req immediately and completes two cycles later.
module tb_nand_dqs_cal_ctrl;

  logic       clk0 = 1'b0;
  logic       rst0_n = 1'b0;
  logic       cal_start = 1'b0;
  logic       rd_ack = 1'b0;
  logic       rd_done = 1'b0;
  logic       rd_pass = 1'b0;
  logic       rd_req, dlyrst_dqs, dlyce_dqs, dlyinc_dqs;
  logic       cal_busy, cal_done, cal_err;
  logic [4:0] cur_tap, win_start;
  logic [5:0] win_len;

  int total = 0;
  int bad = 0;

  // IDELAY model and pulse bookkeeping
  int   tap_m = 0;
  int   rst_cnt = 0;
  int   ce_cnt = 0;
  int   ce_since_rst = 0;
  int   wrap_cnt = 0;
  int   both_cnt = 0;
  int   dbl_rst_cnt = 0;
  int   rd_cnt = 0;
  logic prev_rst = 1'b0;

  localparam int RESET_VEC = 32'h0008_0000;  // only dlyinc_dqs set

  always #5 clk0 = ~clk0;

  nand_dqs_cal_ctrl dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .cal_start  (cal_start),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_done    (rd_done),
    .rd_pass    (rd_pass),
    .dlyrst_dqs (dlyrst_dqs),
    .dlyce_dqs  (dlyce_dqs),
    .dlyinc_dqs (dlyinc_dqs),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_err    (cal_err),
    .cur_tap    (cur_tap),
    .win_start  (win_start),
    .win_len    (win_len)
  );

  always @(posedge clk0) begin
    prev_rst <= dlyrst_dqs;
    if (dlyrst_dqs && dlyce_dqs) both_cnt <= both_cnt + 1;
    if (dlyrst_dqs && prev_rst) dbl_rst_cnt <= dbl_rst_cnt + 1;
    if (dlyrst_dqs) begin
      tap_m        <= 0;
      rst_cnt      <= rst_cnt + 1;
      ce_since_rst <= 0;
    end else if (dlyce_dqs && dlyinc_dqs) begin
      if (tap_m == 31) wrap_cnt <= wrap_cnt + 1;
      tap_m        <= (tap_m + 1) % 32;
      ce_cnt       <= ce_cnt + 1;
      ce_since_rst <= ce_since_rst + 1;
    end
    if (rd_req && rd_ack) rd_cnt <= rd_cnt + 1;
  end

  function automatic int outs();
    return int'({rd_req, dlyrst_dqs, dlyce_dqs, dlyinc_dqs, cal_busy, cal_done, cal_err,
                 cur_tap, win_start, win_len});
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a calibration and play the read path until the controller goes idle
  // (or until the read at stop_tap has been accepted). hang_tap never completes.
  task automatic run_cal(input logic [31:0] mask, input int hang_tap, input int stop_tap,
                         input bit poke, output int req_cyc, output int err_cyc,
                         output bit err_at_start);
    int n;
    int cd;
    bit stop;
    bit ended;
    n = 0; cd = 0; stop = 1'b0; ended = 1'b0;
    req_cyc = -1; err_cyc = -1;
    cal_start = 1'b1;
    @(negedge clk0);
    err_at_start = cal_err;
    while (n < 8000) begin
      rd_ack = 1'b0; rd_done = 1'b0; rd_pass = 1'b0; cal_start = 1'b0;
      if (stop) begin ended = 1'b1; break; end
      if (cal_err && err_cyc < 0) err_cyc = n;
      if (!cal_busy) begin ended = 1'b1; break; end
      if (poke && n == 100) cal_start = 1'b1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin rd_done = 1'b1; rd_pass = mask[tap_m]; end
      end
      if (rd_req) begin
        rd_ack = 1'b1;
        if (tap_m == hang_tap) begin
          if (req_cyc < 0) req_cyc = n;
        end else begin
          cd = 2;
        end
        if (tap_m == stop_tap) stop = 1'b1;
      end
      @(negedge clk0);
      n++;
    end
    check("run_terminates", int'(ended), 1);
  endtask

  initial begin
    int rq, ec, r0, d0, c0;
    bit eas;

    repeat (3) @(negedge clk0);
    check("reset_outputs", outs(), RESET_VEC);
    rst0_n = 1'b1;
    @(negedge clk0);

    // Taps 10..20 pass; a second cal_start mid-sweep must be ignored
    r0 = rst_cnt; d0 = rd_cnt;
    run_cal(32'h001F_FC00, -1, -1, 1'b1, rq, ec, eas);
    check("t1_done", int'(cal_done), 1);
    check("t1_err", int'(cal_err), 0);
    check("t1_busy", int'(cal_busy), 0);
    check("t1_win_start", int'(win_start), 10);
    check("t1_win_len", int'(win_len), 11);
    check("t1_cur_tap", int'(cur_tap), 15);
    check("t1_model_tap", tap_m, 15);
    check("t1_ce_after_rst", ce_since_rst, 15);
    check("t1_reads", rd_cnt - d0, 32);
    check("t1_rst_pulses", rst_cnt - r0, 2);

    // Two windows, longer one wins
    run_cal(32'h03FF_F038, -1, -1, 1'b0, rq, ec, eas);
    check("t2_win_start", int'(win_start), 12);
    check("t2_win_len", int'(win_len), 14);
    check("t2_cur_tap", int'(cur_tap), 18);
    check("t2_model_tap", tap_m, 18);

    // Equal windows, earlier one kept
    run_cal(32'h0000_071C, -1, -1, 1'b0, rq, ec, eas);
    check("t3_win_start", int'(win_start), 2);
    check("t3_win_len", int'(win_len), 3);
    check("t3_cur_tap", int'(cur_tap), 3);
    check("t3_ce_after_rst", ce_since_rst, 3);

    // Window runs into the last tap
    run_cal(32'hF000_0000, -1, -1, 1'b0, rq, ec, eas);
    check("t4_done", int'(cal_done), 1);
    check("t4_win_start", int'(win_start), 28);
    check("t4_win_len", int'(win_len), 4);
    check("t4_cur_tap", int'(cur_tap), 29);
    check("t4_model_tap", tap_m, 29);

    // No passing tap at all
    run_cal(32'h0000_0000, -1, -1, 1'b0, rq, ec, eas);
    check("t5_err", int'(cal_err), 1);
    check("t5_done", int'(cal_done), 0);
    check("t5_win_len", int'(win_len), 0);
    check("t5_busy", int'(cal_busy), 0);
    check("t5_model_tap", tap_m, 31);

    // Window too short
    run_cal(32'h0000_0180, -1, -1, 1'b0, rq, ec, eas);
    check("t6_err", int'(cal_err), 1);
    check("t6_done", int'(cal_done), 0);
    check("t6_win_start", int'(win_start), 7);
    check("t6_win_len", int'(win_len), 2);

    // Read never completes at tap 5
    r0 = rst_cnt; d0 = rd_cnt;
    run_cal(32'h001F_FC00, 5, -1, 1'b0, rq, ec, eas);
    check("t7_err", int'(cal_err), 1);
    check("t7_busy", int'(cal_busy), 0);
    check("t7_timeout_cycles", ec - rq, 255);
    check("t7_model_tap", tap_m, 5);
    check("t7_cur_tap", int'(cur_tap), 5);
    check("t7_reads", rd_cnt - d0, 6);

    // Restart after error
    r0 = rst_cnt;
    run_cal(32'h001F_FC00, -1, -1, 1'b0, rq, ec, eas);
    check("t8_err_cleared", int'(eas), 0);
    check("t8_done", int'(cal_done), 1);
    check("t8_win_start", int'(win_start), 10);
    check("t8_cur_tap", int'(cur_tap), 15);
    check("t8_rst_pulses", rst_cnt - r0, 2);

    // Asynchronous reset while waiting for the read at tap 9
    run_cal(32'h0000_001C, -1, 9, 1'b0, rq, ec, eas);
    check("t9_busy_before", int'(cal_busy), 1);
    check("t9_win_len_before", int'(win_len), 3);
    check("t9_model_tap", tap_m, 9);
    c0 = ce_cnt; r0 = rst_cnt;
    #2 rst0_n = 1'b0;
    #1 check("t9_async_reset", outs(), RESET_VEC);
    repeat (3) @(negedge clk0);
    check("t9_no_ce", ce_cnt - c0, 0);
    check("t9_no_rst", rst_cnt - r0, 0);
    rst0_n = 1'b1;

    // Stray completion while idle
    d0 = rd_cnt;
    @(negedge clk0);
    rd_done = 1'b1; rd_pass = 1'b1;
    @(negedge clk0);
    rd_done = 1'b0; rd_pass = 1'b0;
    repeat (2) @(negedge clk0);
    check("t10_stray_done", outs(), RESET_VEC);
    check("t10_no_reads", rd_cnt - d0, 0);

    check("never_wraps", wrap_cnt, 0);
    check("ce_rst_exclusive", both_cnt, 0);
    check("rst_single_cycle", dbl_rst_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
